// File: rtl/hazard_stall_unit.sv
// Stall/flush controller for load-use, taken-branch and multi-cycle data-memory hazards, with memory-wait timeout and saturating counters.
// Stall/flush outputs are combinational from state + inputs (zero-cycle); a data-memory wait freezes the whole pipe until MemReadyM.
module hazard_stall_unit #(
    parameter int WAIT_MAX = 255,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       Rs1_D,
    input  logic [4:0]       Rs2_D,
    input  logic [4:0]       RdE,
    input  logic             MemReadE,
    input  logic             PCSrcE,
    input  logic             MemReqM,
    input  logic             MemReadyM,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic             MemTimeout,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
);

    localparam int WCNT_W = $clog2(WAIT_MAX + 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic              timeout_q, timeout_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic lu, mw;
    logic freeze, run_eval, br_flush, lu_stall;

    assign lu = MemReadE & (RdE != 5'd0) & ((RdE == Rs1_D) | (RdE == Rs2_D));
    assign mw = MemReqM & ~MemReadyM;

    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        timeout_d = timeout_q;
        freeze    = 1'b0;
        run_eval  = 1'b0;
        case (state_q)
            RUN: begin
                if (mw) begin
                    freeze  = 1'b1;
                    state_d = MEM_WAIT;
                    wcnt_d  = WCNT_W'(1);
                end else begin
                    run_eval = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (MemReadyM) begin
                    run_eval = 1'b1;
                    state_d  = RUN;
                    wcnt_d   = '0;
                end else if (wcnt_q == WCNT_W'(WAIT_MAX)) begin
                    freeze    = 1'b1;
                    timeout_d = 1'b1;
                    state_d   = ERR;
                end else begin
                    freeze = 1'b1;
                    wcnt_d = wcnt_q + WCNT_W'(1);
                end
            end
            ERR: begin
                // Only reset leaves ERR.
                freeze = 1'b1;
            end
            default: begin
                state_d = RUN;
                wcnt_d  = '0;
            end
        endcase
    end

    // A flushed Decode instruction cannot cause a load-use stall.
    assign br_flush = run_eval & PCSrcE;
    assign lu_stall = run_eval & ~PCSrcE & lu;

    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushW = 1'b0;
        if (!rst) begin
            StallF = freeze | lu_stall;
            StallD = freeze | lu_stall;
            StallE = freeze;
            StallM = freeze;
            FlushD = br_flush;
            FlushE = br_flush | lu_stall;
            FlushW = freeze;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (StallF && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if ((FlushD || FlushE) && (flush_cnt_q != {CNT_W{1'b1}})) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            wcnt_q      <= '0;
            timeout_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            timeout_q   <= timeout_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign MemTimeout = timeout_q;
    assign StallCount = stall_cnt_q;
    assign FlushCount = flush_cnt_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Bench for hazard_stall_unit: directed vector table followed by random stimulus against a cycle-level reference model.
module tb_hazard_stall_unit;

    localparam int WAIT_MAX = 4;
    localparam int CNT_W    = 3;
    localparam int SAT      = (1 << CNT_W) - 1;

    localparam logic [6:0] NON = 7'b0000000;
    localparam logic [6:0] FRZ = 7'b1111001;
    localparam logic [6:0] FLS = 7'b0000110;
    localparam logic [6:0] LUS = 7'b1100010;

    typedef struct {
        logic       rst;
        logic [4:0] rs1, rs2, rd;
        logic       mr, pc, mq, my;
        logic [6:0] ctl;
        logic       to;
        int         sc, fc;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic [4:0] Rs1_D, Rs2_D, RdE;
    logic MemReadE, PCSrcE, MemReqM, MemReadyM;
    logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemTimeout;
    logic [CNT_W-1:0] StallCount, FlushCount;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model state: wait cycles spent frozen so far, error lock, counters.
    int m_wait = 0;
    bit m_err  = 1'b0;
    int m_sc   = 0;
    int m_fc   = 0;

    vec_t tbl[$];

    always #5 clk = ~clk;

    hazard_stall_unit #(.WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .RdE(RdE),
        .MemReadE(MemReadE), .PCSrcE(PCSrcE), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .MemTimeout(MemTimeout), .StallCount(StallCount), .FlushCount(FlushCount)
    );

    function automatic bit model_frozen(input vec_t v);
        bit mw;
        mw = v.mq && !v.my;
        if (m_err) return 1'b1;
        if (m_wait > 0) return !v.my;
        return mw;
    endfunction

    function automatic logic [6:0] model_ctl(input vec_t v);
        bit lu;
        lu = v.mr && (v.rd != 0) && ((v.rd == v.rs1) || (v.rd == v.rs2));
        if (v.rst) return NON;
        if (model_frozen(v)) return FRZ;
        if (v.pc) return FLS;
        if (lu) return LUS;
        return NON;
    endfunction

    task automatic model_update(input vec_t v);
        logic [6:0] c;
        bit fr;
        c  = model_ctl(v);
        fr = model_frozen(v);
        if (v.rst) begin
            m_wait = 0; m_err = 1'b0; m_sc = 0; m_fc = 0;
        end else begin
            if (c[6] && m_sc < SAT) m_sc = m_sc + 1;
            if ((c[2] || c[1]) && m_fc < SAT) m_fc = m_fc + 1;
            if (!m_err) begin
                if (fr) begin
                    if (m_wait == WAIT_MAX) begin
                        m_err = 1'b1; m_wait = 0;
                    end else begin
                        m_wait = m_wait + 1;
                    end
                end else begin
                    m_wait = 0;
                end
            end
        end
    endtask

    task automatic step(input vec_t v, input string nm);
        logic [6:0] act;
        @(negedge clk);
        rst = v.rst; Rs1_D = v.rs1; Rs2_D = v.rs2; RdE = v.rd;
        MemReadE = v.mr; PCSrcE = v.pc; MemReqM = v.mq; MemReadyM = v.my;
        #1;
        act = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};
        n_vec++;
        if (act !== v.ctl || MemTimeout !== v.to ||
            int'(StallCount) != v.sc || int'(FlushCount) != v.fc ||
            $isunknown({StallCount, FlushCount})) begin
            n_bad++;
            $display("FAIL %s: got ctl=%b to=%b sc=%0d fc=%0d, want ctl=%b to=%b sc=%0d fc=%0d",
                     nm, act, MemTimeout, StallCount, FlushCount, v.ctl, v.to, v.sc, v.fc);
        end
        @(posedge clk);
        model_update(v);
    endtask

    task automatic add(input logic r, input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
                       input logic mr, input logic pc, input logic mq, input logic my,
                       input logic [6:0] c, input logic t, input int sc, input int fc);
        vec_t v;
        v.rst = r; v.rs1 = a; v.rs2 = b; v.rd = d;
        v.mr = mr; v.pc = pc; v.mq = mq; v.my = my;
        v.ctl = c; v.to = t; v.sc = sc; v.fc = fc;
        tbl.push_back(v);
    endtask

    initial begin
        vec_t v;
        rst = 1'b1; Rs1_D = '0; Rs2_D = '0; RdE = '0;
        MemReadE = 1'b0; PCSrcE = 1'b0; MemReqM = 1'b0; MemReadyM = 1'b0;
        repeat (2) @(posedge clk);

        // rst rs1 rs2 rd  mr pc mq my   ctl  to  sc fc   (counts are pre-edge)
        add(1, 0, 0, 0, 0, 0, 0, 0, NON, 0, 0, 0);
        add(0, 5, 0, 5, 1, 0, 0, 0, LUS, 0, 0, 0);
        add(0, 5, 0, 5, 0, 0, 0, 0, NON, 0, 1, 1);
        add(0, 0, 0, 0, 1, 0, 0, 0, NON, 0, 1, 1);
        add(0, 3, 4, 7, 1, 0, 0, 0, NON, 0, 1, 1);
        add(0, 1, 5, 5, 1, 1, 0, 0, FLS, 0, 1, 1);
        add(0, 0, 0, 0, 0, 0, 0, 0, NON, 0, 1, 2);
        add(0, 0, 0, 0, 0, 0, 1, 0, FRZ, 0, 1, 2);
        add(0, 0, 0, 0, 0, 1, 1, 0, FRZ, 0, 2, 2);
        add(0, 0, 0, 0, 0, 1, 1, 0, FRZ, 0, 3, 2);
        add(0, 0, 0, 0, 0, 1, 1, 1, FLS, 0, 4, 2);
        add(0, 0, 0, 0, 0, 0, 0, 0, NON, 0, 4, 3);
        add(0, 0, 0, 0, 0, 0, 1, 1, NON, 0, 4, 3);
        add(1, 0, 0, 0, 0, 0, 1, 0, NON, 0, 4, 3);
        for (int i = 0; i < 5; i++) add(0, 0, 0, 0, 0, 0, 1, 0, FRZ, 0, i, 0);
        add(0, 0, 0, 0, 0, 0, 0, 1, FRZ, 1, 5, 0);
        add(0, 0, 0, 0, 0, 0, 1, 1, FRZ, 1, 6, 0);
        add(0, 2, 0, 2, 1, 1, 0, 1, FRZ, 1, 7, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, FRZ, 1, 7, 0);
        add(1, 0, 0, 0, 0, 0, 0, 0, NON, 1, 7, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, NON, 0, 0, 0);
        for (int i = 0; i < 10; i++)
            add(0, 3, 0, 3, 1, 0, 0, 0, LUS, 0, (i < SAT) ? i : SAT, (i < SAT) ? i : SAT);
        add(0, 0, 0, 0, 0, 0, 0, 0, NON, 0, SAT, SAT);

        foreach (tbl[i]) step(tbl[i], $sformatf("row%0d", i));

        // Hand sequence: reset taken mid-wait returns straight to RUN.
        add(0, 0, 0, 0, 0, 0, 1, 0, FRZ, 0, SAT, SAT);
        add(0, 0, 0, 0, 0, 0, 1, 0, FRZ, 0, SAT, SAT);
        add(1, 0, 0, 0, 0, 0, 1, 0, NON, 0, SAT, SAT);
        add(0, 4, 4, 4, 1, 0, 0, 0, LUS, 0, 0, 0);
        for (int i = tbl.size() - 4; i < tbl.size(); i++) step(tbl[i], $sformatf("midwait%0d", i));

        for (int i = 0; i < 600; i++) begin
            v.rst = ($urandom_range(0, 63) == 0);
            v.rs1 = 5'($urandom_range(0, 3));
            v.rs2 = 5'($urandom_range(0, 3));
            v.rd  = 5'($urandom_range(0, 3));
            v.mr  = 1'($urandom_range(0, 1));
            v.pc  = ($urandom_range(0, 3) == 0);
            v.mq  = ($urandom_range(0, 2) == 0);
            v.my  = 1'($urandom_range(0, 1));
            v.ctl = model_ctl(v);
            v.to  = m_err;
            v.sc  = m_sc;
            v.fc  = m_fc;
            step(v, $sformatf("rand%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
